// File: rtl/rs_alu_pkg.sv
// Shared constants and types for the integer ALU reservation station.
// Operand snooping is a helper so dispatch capture and wakeup use the same rule.
package rs_alu_pkg;

    localparam int ROB_BIT = 4;
    localparam int RS_SIZE = 8;
    localparam int RS_BIT  = 3;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] B_TYPE = 7'b1100011;

    typedef logic [ROB_BIT-1:0] rob_tag_t;

    typedef struct packed {
        logic        pending;
        rob_tag_t    tag;
        logic [31:0] value;
    } operand_t;

    typedef struct packed {
        logic        ready;
        rob_tag_t    rob;
        logic [31:0] res;
    } cdb_t;

    typedef struct packed {
        logic       busy;
        logic [2:0] op;
        logic [6:0] op_type;
        logic       op_addition;
        rob_tag_t   rob;
        operand_t   opi;
        operand_t   opj;
    } rs_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] vi;
        logic [31:0] vj;
        logic [2:0]  op;
        logic [6:0]  op_type;
        logic        op_addition;
        rob_tag_t    rob_entry;
    } issue_t;

    // ALU channel is checked first so it wins if both channels carry the tag.
    function automatic operand_t snoop(input operand_t cur, input cdb_t alu, input cdb_t lsb);
        operand_t r;
        r = cur;
        if (cur.pending) begin
            if (alu.ready && alu.rob == cur.tag) begin
                r.pending = 1'b0;
                r.value   = alu.res;
            end else if (lsb.ready && lsb.rob == cur.tag) begin
                r.pending = 1'b0;
                r.value   = lsb.res;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_alu_if.sv
// Dispatch, CDB snoop and ALU issue signals around the ALU reservation station.
// The station is the master: it initiates issue towards the ALU.
interface rs_alu_if;
    import rs_alu_pkg::*;

    logic        rob_clear_up;

    logic        disp_valid;
    logic [2:0]  disp_op;
    logic [6:0]  disp_op_type;
    logic        disp_op_addition;
    logic [31:0] disp_vi;
    logic [31:0] disp_vj;
    logic        disp_qi_valid;
    logic        disp_qj_valid;
    rob_tag_t    disp_qi;
    rob_tag_t    disp_qj;
    rob_tag_t    disp_rob_entry;
    logic        full;

    logic        alu_cdb_ready;
    logic [31:0] alu_cdb_res;
    rob_tag_t    alu_cdb_rob;
    logic        lsb_cdb_ready;
    logic [31:0] lsb_cdb_res;
    rob_tag_t    lsb_cdb_rob;

    logic        valid;
    logic [31:0] vi;
    logic [31:0] vj;
    logic [2:0]  op;
    logic [6:0]  op_type;
    logic        op_addition;
    rob_tag_t    rob_entry;

    modport master (
        input  rob_clear_up,
        input  disp_valid, disp_op, disp_op_type, disp_op_addition,
        input  disp_vi, disp_vj, disp_qi_valid, disp_qj_valid,
        input  disp_qi, disp_qj, disp_rob_entry,
        output full,
        input  alu_cdb_ready, alu_cdb_res, alu_cdb_rob,
        input  lsb_cdb_ready, lsb_cdb_res, lsb_cdb_rob,
        output valid, vi, vj, op, op_type, op_addition, rob_entry
    );

    modport slave (
        output rob_clear_up,
        output disp_valid, disp_op, disp_op_type, disp_op_addition,
        output disp_vi, disp_vj, disp_qi_valid, disp_qj_valid,
        output disp_qi, disp_qj, disp_rob_entry,
        input  full,
        output alu_cdb_ready, alu_cdb_res, alu_cdb_rob,
        output lsb_cdb_ready, lsb_cdb_res, lsb_cdb_rob,
        input  valid, vi, vj, op, op_type, op_addition, rob_entry
    );

endinterface

// File: rtl/rs_pick_lowest.sv
// Lowest-set-bit priority encoder; used for both free-slot and ready-slot selection.
module rs_pick_lowest #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops, resolves operand tags from both
// CDB channels and issues the lowest-index ready op, one per cycle.
module rs_alu
    import rs_alu_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    rs_alu_if.master  bus
);

    rs_entry_t          ent_q [RS_SIZE];
    rs_entry_t          ent_d [RS_SIZE];
    issue_t             iss_q;
    issue_t             iss_d;
    rs_entry_t          disp_ent;
    cdb_t               alu_cdb;
    cdb_t               lsb_cdb;
    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic               free_found;
    logic               ready_found;
    logic [RS_BIT-1:0]  free_idx;
    logic [RS_BIT-1:0]  ready_idx;
    logic               do_disp;

    assign alu_cdb.ready = bus.alu_cdb_ready;
    assign alu_cdb.rob   = bus.alu_cdb_rob;
    assign alu_cdb.res   = bus.alu_cdb_res;
    assign lsb_cdb.ready = bus.lsb_cdb_ready;
    assign lsb_cdb.rob   = bus.lsb_cdb_rob;
    assign lsb_cdb.res   = bus.lsb_cdb_res;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && !ent_q[i].opi.pending && !ent_q[i].opj.pending;
        end
    end

    rs_pick_lowest #(.N(RS_SIZE), .W(RS_BIT)) u_pick_free (
        .req   (~busy_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_pick_lowest #(.N(RS_SIZE), .W(RS_BIT)) u_pick_ready (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (ready_idx)
    );

    assign bus.full = &busy_vec;
    assign do_disp  = rdy_in && bus.disp_valid && free_found;

    // Incoming op with same-cycle CDB capture applied.
    always_comb begin
        disp_ent             = '0;
        disp_ent.busy        = 1'b1;
        disp_ent.op          = bus.disp_op;
        disp_ent.op_type     = bus.disp_op_type;
        disp_ent.op_addition = bus.disp_op_addition;
        disp_ent.rob         = bus.disp_rob_entry;
        disp_ent.opi.pending = bus.disp_qi_valid;
        disp_ent.opi.tag     = bus.disp_qi;
        disp_ent.opi.value   = bus.disp_vi;
        disp_ent.opj.pending = bus.disp_qj_valid;
        disp_ent.opj.tag     = bus.disp_qj;
        disp_ent.opj.value   = bus.disp_vj;
        disp_ent.opi         = snoop(disp_ent.opi, alu_cdb, lsb_cdb);
        disp_ent.opj         = snoop(disp_ent.opj, alu_cdb, lsb_cdb);
    end

    // Ready is taken from registered state and the write targets a free slot,
    // so the issued entry and the dispatched entry are always different.
    always_comb begin
        ent_d = ent_q;
        iss_d = iss_q;
        if (rdy_in) begin
            iss_d.valid = 1'b0;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy) begin
                    ent_d[i].opi = snoop(ent_q[i].opi, alu_cdb, lsb_cdb);
                    ent_d[i].opj = snoop(ent_q[i].opj, alu_cdb, lsb_cdb);
                end
            end
            if (ready_found) begin
                iss_d.valid           = 1'b1;
                iss_d.vi              = ent_q[ready_idx].opi.value;
                iss_d.vj              = ent_q[ready_idx].opj.value;
                iss_d.op              = ent_q[ready_idx].op;
                iss_d.op_type         = ent_q[ready_idx].op_type;
                iss_d.op_addition     = ent_q[ready_idx].op_addition;
                iss_d.rob_entry       = ent_q[ready_idx].rob;
                ent_d[ready_idx].busy = 1'b0;
            end
            if (do_disp) begin
                ent_d[free_idx] = disp_ent;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || bus.rob_clear_up) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            iss_q <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
            iss_q <= iss_d;
        end
    end

    assign bus.valid       = iss_q.valid;
    assign bus.vi          = iss_q.vi;
    assign bus.vj          = iss_q.vj;
    assign bus.op          = iss_q.op;
    assign bus.op_type     = iss_q.op_type;
    assign bus.op_addition = iss_q.op_addition;
    assign bus.rob_entry   = iss_q.rob_entry;

endmodule
